// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants. S_HALT exists only when
// FETCH_HALT_DETECT_EN is defined.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t HALT_OPCODE = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
`ifdef FETCH_HALT_DETECT_EN
    S_EXEC = 2'd2,
    S_HALT = 2'd3
`else
    S_EXEC = 2'd2
`endif
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// 16-bit program counter with asynchronous reset.
// A load takes priority over an increment.
module pc_counter
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = '0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  word_t load_val_i,
  input  logic  inc_i,
  output word_t pc_o
);

  word_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_val_i;
    else if (inc_i)
      pc_d = pc_q + word_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: request, capture into IR with a one-cycle strobe, wait
// for execute. FETCH_HALT_DETECT_EN enables parking on the HALT opcode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir_d,
  output logic              ir_en,
  output logic [WORD_W-1:0] pc,
  input  logic              stall,
  input  logic              exec_done,
  input  logic              branch_valid,
  input  logic [WORD_W-1:0] branch_target,
  output logic              halted
);

  fetch_state_e state_q, state_d;
  word_t        ir_word_q, ir_word_d;
  logic         ir_en_q, ir_en_d;
  logic         start_q;
  logic         pc_inc, pc_load;

  always_comb begin
    state_d   = state_q;
    ir_word_d = ir_word_q;
    ir_en_d   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    case (state_q)
      // start_q holds off the first request until the second edge after reset
      S_IDLE: if (start_q && !stall) state_d = S_REQ;
      S_REQ: begin
        if (mem_ack) begin
          ir_word_d = mem_rdata;
          ir_en_d   = 1'b1;
          pc_inc    = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
          state_d   = (mem_rdata == HALT_OPCODE) ? S_HALT : S_EXEC;
`else
          state_d   = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_IDLE;
          pc_load = branch_valid;
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_word_q <= '0;
      ir_en_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_word_q <= ir_word_d;
      ir_en_q   <= ir_en_d;
      start_q   <= 1'b1;
    end
  end

  pc_counter #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (pc_load),
    .load_val_i(branch_target),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = pc;
  assign ir_d     = ir_word_q;
  assign ir_en    = ir_en_q;
`ifdef FETCH_HALT_DETECT_EN
  assign halted   = (state_q == S_HALT);
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-abort sequence, and a
// randomized run against a transaction-level model of the fetch protocol.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, mem_req, mem_ack, ir_en, stall, exec_done, branch_valid, halted;
  logic [15:0] mem_addr, mem_rdata, ir_d, pc, branch_target;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit H = 1'b1;
`else
  localparam bit H = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ir_d         (ir_d),
    .ir_en        (ir_en),
    .pc           (pc),
    .stall        (stall),
    .exec_done    (exec_done),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .halted       (halted)
  );

  typedef struct {
    logic        stall;
    logic        ack;
    logic [15:0] rdata;
    logic        ed;
    logic        bv;
    logic [15:0] bt;
    logic        req;
    logic        ien;
    logic [15:0] ird;
    logic [15:0] pc;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic [15:0] rd,
                       input logic ed, input logic bv, input logic [15:0] bt);
    stall = s; mem_ack = a; mem_rdata = rd;
    exec_done = ed; branch_valid = bv; branch_target = bt;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {15'd0, mem_req}, 16'd0);
    check("rst_ien", {15'd0, ir_en}, 16'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_ird", ir_d, 16'h0000);
    check("rst_hlt", {15'd0, halted}, 16'd0);
    reset = 1'b1;
  endtask

  task automatic wait_req(input string name, input int budget);
    for (int i = 0; i < budget && !mem_req; i++) begin
      @(posedge clk); #1;
    end
    check(name, {15'd0, mem_req}, 16'd1);
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [15:0] w;
    w = (a * 16'h9E37) ^ 16'h5A5A;
    if (w == 16'hFFFF) w = 16'h0001;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // stall ack rdata ed bv bt | req ien ird pc hlt
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'h0000,1'b0});
    tbl.push_back('{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h1234,16'h0001,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h00A0, 1'b0,1'b0,16'h1234,16'h0001,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h1234,16'h0001,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h1234,16'h0001,1'b0});
    tbl.push_back('{1'b0,1'b1,16'h0BEE,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h0BEE,16'h0002,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h00A0, 1'b0,1'b0,16'h0BEE,16'h00A0,1'b0});
    tbl.push_back('{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h0BEE,16'h00A0,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0BEE,16'h00A0,1'b0});
    tbl.push_back('{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0BEE,16'h00A0,1'b0});
    tbl.push_back('{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0BEE,16'h00A0,1'b0});
    tbl.push_back('{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0BEE,16'h00A0,1'b0});
    tbl.push_back('{1'b1,1'b1,16'h5555,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h5555,16'h00A1,1'b0});
    tbl.push_back('{1'b0,1'b1,16'h7777,1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h5555,16'h00A1,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b1,16'hFFFF, 1'b0,1'b0,16'h5555,16'hFFFF,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h5555,16'hFFFF,1'b0});
    tbl.push_back('{1'b0,1'b1,16'h4321,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h4321,16'h0000,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h4321,16'h0000,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h4321,16'h0000,1'b0});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h1111, 1'b1,1'b0,16'h4321,16'h0000,1'b0});
    tbl.push_back('{1'b0,1'b1,16'hFFFF,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'hFFFF,16'h0001,H});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'hFFFF,16'h0001,H});
    tbl.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, !H,  1'b0,16'hFFFF,16'h0001,H});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].ack, tbl[i].rdata, tbl[i].ed, tbl[i].bv, tbl[i].bt);
      @(posedge clk); #1;
      check($sformatf("vec%0d_req", i), {15'd0, mem_req}, {15'd0, tbl[i].req});
      check($sformatf("vec%0d_ien", i), {15'd0, ir_en}, {15'd0, tbl[i].ien});
      check($sformatf("vec%0d_ird", i), ir_d, tbl[i].ird);
      check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("vec%0d_addr", i), mem_addr, tbl[i].pc);
      check($sformatf("vec%0d_hlt", i), {15'd0, halted}, {15'd0, tbl[i].hlt});
    end

`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'($urandom_range(0, 1)), 1'b0, 16'h0000);
      @(posedge clk); #1;
      check("halt_noreq", {15'd0, mem_req}, 16'd0);
      check("halt_flag", {15'd0, halted}, 16'd1);
    end
`endif

    // Reset in the middle of an outstanding request.
    do_reset();
    wait_req("abort_wait1", 6);
    drive(1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    wait_req("abort_wait2", 6);
    check("abort_pc_before", pc, 16'h0001);
    drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000);
    #2 reset = 1'b0;
    #1;
    check("abort_req_async", {15'd0, mem_req}, 16'd0);
    check("abort_pc_async", pc, RST_PC);
    @(posedge clk); #1;
    check("abort_ien", {15'd0, ir_en}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_ien_after", {15'd0, ir_en}, 16'd0);
      check("abort_ird_after", ir_d, 16'h0000);
    end

    // Randomized run against a transaction-level model.
    begin
      logic [15:0] exp_addr, last_word, rd, bt;
      logic        in_exec, strobe_exp, hold_exp, s, a, ed, bv;
      int          idle;
      do_reset();
      exp_addr  = RST_PC;
      last_word = 16'h0000;
      in_exec   = 1'b0;
      idle      = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        s  = ($urandom_range(0, 3) == 0);
        a  = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
        rd = 16'($urandom);
        if (mem_req && a) rd = word_of(exp_addr);
        ed = in_exec ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
        bv = 1'($urandom_range(0, 1));
        bt = 16'($urandom);
        drive(s, a, rd, ed, bv, bt);
        strobe_exp = mem_req && a;
        hold_exp   = mem_req && !a;
        if (strobe_exp) begin
          exp_addr  = exp_addr + 16'd1;
          last_word = rd;
          in_exec   = 1'b1;
        end else if (in_exec && ed) begin
          in_exec = 1'b0;
          if (bv) exp_addr = bt;
        end
        @(posedge clk); #1;
        check("rnd_ien", {15'd0, ir_en}, {15'd0, strobe_exp});
        check("rnd_ird", ir_d, last_word);
        check("rnd_pc", pc, exp_addr);
        check("rnd_addr", mem_addr, exp_addr);
        check("rnd_hlt", {15'd0, halted}, 16'd0);
        if (hold_exp) check("rnd_req_hold", {15'd0, mem_req}, 16'd1);
        if (in_exec) check("rnd_req_exec", {15'd0, mem_req}, 16'd0);
        if (!mem_req && !in_exec) idle++;
        else idle = 0;
        if (idle > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_progress: got no request for %0d cycles expected at most 40", idle);
          break;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
